// File: rtl/regfile_pkg.sv
// Shared constants, typedefs and packed-port helpers for the multi-port register file.
// Build option REGFILE_BYPASS_EN (used by regfile_mp) selects same-cycle write-to-read forwarding.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

    // Low bit position of field `port` in a packed bus of `width`-bit fields.
    function automatic int port_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, reservation wins over a same-cycle write clear.
// busy_d is the next-state vector, exported so the read path can forward it.
module rf_scoreboard #(
    parameter int ADDR_W   = regfile_pkg::DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_q,
    output logic [(1<<ADDR_W)-1:0]   busy_d
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    // Set is applied after clear: a new reservation belongs to a later producer.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads and a write-pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and post-edge busy state to reads.
module regfile_mp #(
    parameter int DATA_W   = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W   = regfile_pkg::DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv,
    input  logic [ADDR_W-1:0]          rsv_addr
);

    import regfile_pkg::*;

    localparam int DEPTH   = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS  = 1'b1;
`else
    localparam bit BYPASS  = 1'b0;
`endif

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_ok;

    assign wr_ok = we && !(ZERO_EN && wr_addr == '0);

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (wr_addr),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .busy_q   (busy_q),
        .busy_d   (busy_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_n;
        logic              busy_n;
        logic [DATA_W-1:0] data_q;
        logic              busy_r;

        assign addr = rd_addr[port_slice(p, ADDR_W) +: ADDR_W];

        // Data and busy are both taken pre-edge, or both post-edge when forwarding.
        always_comb begin
            data_n = mem[addr];
            busy_n = busy_q[addr];
            if (BYPASS) begin
                busy_n = busy_d[addr];
                if (wr_ok && addr == wr_addr) begin
                    data_n = wr_data;
                end
            end
            if (ZERO_EN && addr == '0) begin
                data_n = '0;
                busy_n = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_r <= 1'b0;
            end else if (en) begin
                data_q <= data_n;
                busy_r <= busy_n;
            end
        end

        assign rd_data[port_slice(p, DATA_W) +: DATA_W] = data_q;
        assign rd_busy[p] = busy_r;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default configuration plus a 32-bit/5-bit/3-port sweep with ZERO_REG=0.
// Directed test-plan cases followed by randomized traffic against an array-based reference model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A: DATA_W=16 ADDR_W=4 NUM_RD=2 ZERO_REG=1
    logic        a_en, a_we, a_rsv;
    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [3:0]  a_wr_addr, a_rsv_addr;
    logic [15:0] a_wr_data;

    // instance B: DATA_W=32 ADDR_W=5 NUM_RD=3 ZERO_REG=0
    logic        b_en, b_we, b_rsv;
    logic [14:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [4:0]  b_wr_addr, b_rsv_addr;
    logic [31:0] b_wr_data;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv(a_rsv), .rsv_addr(a_rsv_addr)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv(b_rsv), .rsv_addr(b_rsv_addr)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    logic [31:0] e_data [2][4];
    bit          e_busy [2][4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                e_data[k][p] = '0;
                e_busy[k][p] = 1'b0;
            end
        end
    endtask

    // One clock edge of the reference register file k.
    task automatic model_edge(input int k, input bit en_i, input logic [19:0] ra, input bit we_i,
                              input int wa, input logic [31:0] wd, input bit rsv_i, input int rva);
        int  aw, np, a;
        bit  zr, wok, rok, b;
        logic [31:0] d;
        aw  = (k == 0) ? 4 : 5;
        np  = (k == 0) ? 2 : 3;
        zr  = (k == 0);
        wok = we_i && !(zr && wa == 0);
        rok = rsv_i && !(zr && rva == 0);
        if (en_i) begin
            for (int p = 0; p < np; p++) begin
                a = int'((ra >> (p * aw)) & ((20'd1 << aw) - 20'd1));
                d = m_mem[k][a];
                b = m_busy[k][a];
`ifdef REGFILE_BYPASS_EN
                if (wok && a == wa) begin
                    d = wd;
                    b = 1'b0;
                end
                if (rok && a == rva) b = 1'b1;
`endif
                if (zr && a == 0) begin
                    d = '0;
                    b = 1'b0;
                end
                e_data[k][p] = d;
                e_busy[k][p] = b;
            end
        end
        if (wok) begin
            m_mem[k][wa]  = wd;
            m_busy[k][wa] = 1'b0;
        end
        if (rok) m_busy[k][rva] = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s_a_data%0d", tag, p), {16'b0, a_rd_data[p*16 +: 16]}, e_data[0][p]);
            check($sformatf("%s_a_busy%0d", tag, p), {31'b0, a_rd_busy[p]}, {31'b0, e_busy[0][p]});
        end
        for (int p = 0; p < 3; p++) begin
            check($sformatf("%s_b_data%0d", tag, p), b_rd_data[p*32 +: 32], e_data[1][p]);
            check($sformatf("%s_b_busy%0d", tag, p), {31'b0, b_rd_busy[p]}, {31'b0, e_busy[1][p]});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_data"}, a_rd_data, 32'h0);
        check({tag, "_a_busy"}, {30'b0, a_rd_busy}, 32'h0);
        check({tag, "_b_data_lo"}, b_rd_data[31:0], 32'h0);
        check({tag, "_b_data_hi"}, b_rd_data[95:32] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        check({tag, "_b_busy"}, {29'b0, b_rd_busy}, 32'h0);
    endtask

    // Called just after a falling edge with inputs driven; returns just after the next falling edge.
    task automatic step(input string tag);
        model_edge(0, a_en, {12'b0, a_rd_addr}, a_we, int'(a_wr_addr), {16'b0, a_wr_data},
                   a_rsv, int'(a_rsv_addr));
        model_edge(1, b_en, {5'b0, b_rd_addr}, b_we, int'(b_wr_addr), b_wr_data,
                   b_rsv, int'(b_rsv_addr));
        @(posedge clk);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; a_rsv = 0; a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_rsv_addr = '0;
        b_en = 0; b_we = 0; b_rsv = 0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_addr = '0;
    endtask

    // Mostly low addresses so reads, writes and reservations collide often.
    function automatic int rnd_addr(input int aw);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, (1 << aw) - 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        a_we = 1; a_wr_addr = 4'd2; a_wr_data = 16'hA5A5;
        step("wr_r2"); idle();
        a_en = 1; a_rd_addr = {4'd3, 4'd2};
        step("rd_r3_r2"); idle();
        a_rd_addr = {4'd2, 4'd3};
        step("hold");

        a_we = 1; a_wr_addr = 4'd5; a_wr_data = 16'h0F0F;
        step("wr_r5"); idle();
        a_en = 1; a_rd_addr = {4'd5, 4'd5}; a_we = 1; a_wr_addr = 4'd5; a_wr_data = 16'h1234;
        step("rdwr_r5"); idle();
        a_en = 1; a_rd_addr = {4'd5, 4'd5};
        step("rd_r5"); idle();

        a_rsv = 1; a_rsv_addr = 4'd7;
        step("rsv_r7"); idle();
        a_en = 1; a_rd_addr = {4'd7, 4'd7};
        step("rd_r7_busy"); idle();
        a_we = 1; a_wr_addr = 4'd7; a_wr_data = 16'h00FF;
        step("wr_r7"); idle();
        a_en = 1; a_rd_addr = {4'd7, 4'd7};
        step("rd_r7_free"); idle();
        a_rsv = 1; a_rsv_addr = 4'd7; a_we = 1; a_wr_addr = 4'd7; a_wr_data = 16'h0ABC;
        step("rsvwr_r7"); idle();
        a_en = 1; a_rd_addr = {4'd7, 4'd7};
        step("rd_r7_set_wins"); idle();

        a_we = 1; a_wr_addr = 4'd0; a_wr_data = 16'hFFFF; a_rsv = 1; a_rsv_addr = 4'd0;
        b_we = 1; b_wr_addr = 5'd0; b_wr_data = 32'h0000FFFF;
        step("wr_r0"); idle();
        a_en = 1; a_rd_addr = {4'd0, 4'd0};
        b_en = 1; b_rd_addr = {5'd0, 5'd0, 5'd0};
        step("rd_r0"); idle();

        b_we = 1; b_wr_addr = 5'd31; b_wr_data = 32'hDEADBEEF;
        step("wr_r31"); idle();
        b_en = 1; b_rd_addr = {5'd31, 5'd31, 5'd31};
        step("rd_r31_all"); idle();

        // Asynchronous reset mid-run with a write and reservation pending on the coincident edge.
        a_en = 1; a_rd_addr = {4'd2, 4'd2};
        step("pre_rst"); idle();
        a_we = 1; a_wr_addr = 4'd9; a_wr_data = 16'h1111; a_rsv = 1; a_rsv_addr = 4'd9;
        a_en = 1; a_rd_addr = {4'd9, 4'd2};
        b_we = 1; b_wr_addr = 5'd3; b_wr_data = 32'h55AA55AA; b_en = 1; b_rd_addr = {5'd3, 5'd3, 5'd3};
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_hold");
        @(negedge clk);
        idle();
        model_reset();
        rst = 1'b0;
        a_en = 1; a_rd_addr = {4'd9, 4'd2};
        b_en = 1; b_rd_addr = {5'd31, 5'd3, 5'd3};
        step("post_rst"); idle();

        for (int c = 0; c < 600; c++) begin
            a_en       = 1'($urandom_range(0, 1));
            a_rd_addr  = {4'(rnd_addr(4)), 4'(rnd_addr(4))};
            a_we       = 1'($urandom_range(0, 1));
            a_wr_addr  = 4'(rnd_addr(4));
            a_wr_data  = 16'($urandom);
            a_rsv      = ($urandom_range(0, 2) == 0);
            a_rsv_addr = 4'(rnd_addr(4));
            b_en       = 1'($urandom_range(0, 1));
            b_rd_addr  = {5'(rnd_addr(5)), 5'(rnd_addr(5)), 5'(rnd_addr(5))};
            b_we       = 1'($urandom_range(0, 1));
            b_wr_addr  = 5'(rnd_addr(5));
            b_wr_data  = $urandom;
            b_rsv      = ($urandom_range(0, 2) == 0);
            b_rsv_addr = 5'(rnd_addr(5));
            step("rand");
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
